// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: token-based symbol alignment with bit-slip requests, then 10b->8b decode.
// Optional slip statistics counter built only when TMDS_DECODER_STATS_EN is defined.
module tmds_decoder #(
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 4,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  tmds_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic [7:0]  data_o,
  output logic [1:0]  ctrl_o,
  output logic        de_o,
  output logic [15:0] slip_count_o
);

  localparam int TOK_W  = $clog2(LOCK_COUNT) + 1;
  localparam int TO_W   = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_COUNT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SLIP   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [TOK_W-1:0]    tok_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LOSS_W-1:0]   loss_cnt;

  logic       is_tok;
  logic [1:0] tok_val;
  logic [7:0] d_inv;
  logic [7:0] dec_byte;
  logic       lock_hit;
  logic       slip_fire;

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (tmds_i)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then undo the XOR/XNOR transition chain.
  always_comb begin
    d_inv       = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
    dec_byte    = 8'h00;
    dec_byte[0] = d_inv[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = tmds_i[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
    end
  end

  assign lock_hit  = is_tok && (tok_cnt == TOK_LAST);
  assign slip_fire = (state == S_SEARCH) && !lock_hit && (to_cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_SEARCH;
      tok_cnt   <= '0;
      to_cnt    <= '0;
      wait_cnt  <= '0;
      loss_cnt  <= '0;
      bitslip_o <= 1'b0;
      locked_o  <= 1'b0;
      data_o    <= 8'h00;
      ctrl_o    <= 2'b00;
      de_o      <= 1'b0;
    end else begin
      bitslip_o <= 1'b0;
      data_o    <= 8'h00;
      de_o      <= 1'b0;
      case (state)
        S_SEARCH: begin
          ctrl_o <= 2'b00;
          if (lock_hit) begin
            state    <= S_LOCKED;
            locked_o <= 1'b1;
            tok_cnt  <= '0;
            to_cnt   <= '0;
          end else if (to_cnt == TO_LAST) begin
            state     <= S_SLIP;
            bitslip_o <= 1'b1;
            tok_cnt   <= '0;
            to_cnt    <= '0;
          end else begin
            tok_cnt <= is_tok ? tok_cnt + 1'b1 : '0;
            to_cnt  <= to_cnt + 1'b1;
          end
        end
        S_SLIP: begin
          ctrl_o <= 2'b00;
          if (wait_cnt == WAIT_LAST) begin
            state    <= S_SEARCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (is_tok) begin
            loss_cnt <= '0;
            ctrl_o   <= tok_val;
          end else if (loss_cnt == LOSS_LAST) begin
            state    <= S_SEARCH;
            locked_o <= 1'b0;
            loss_cnt <= '0;
            ctrl_o   <= 2'b00;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
            de_o     <= 1'b1;
            data_o   <= dec_byte;
          end
        end
        default: begin
          state    <= S_SEARCH;
          locked_o <= 1'b0;
          ctrl_o   <= 2'b00;
        end
      endcase
    end
  end

`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] slip_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slip_cnt <= 16'h0000;
    end else if (slip_fire && (slip_cnt != 16'hFFFF)) begin
      slip_cnt <= slip_cnt + 16'h0001;
    end
  end

  assign slip_count_o = slip_cnt;
`else
  assign slip_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: expected outputs queued at drive time, compared one cycle later.
module tb_tmds_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [9:0]  tmds_i = 10'h000;
  logic        bitslip_o;
  logic        locked_o;
  logic [7:0]  data_o;
  logic [1:0]  ctrl_o;
  logic        de_o;
  logic [15:0] slip_count_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [28:0] exp_q[$];
  logic [15:0] exp_slips = 16'h0000;

  tmds_decoder #(
    .LOCK_COUNT(16),
    .SEARCH_TIMEOUT(2048),
    .SLIP_WAIT(4),
    .LOSS_TIMEOUT(2048)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tmds_i(tmds_i),
    .bitslip_o(bitslip_o),
    .locked_o(locked_o),
    .data_o(data_o),
    .ctrl_o(ctrl_o),
    .de_o(de_o),
    .slip_count_o(slip_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (slips|bs|lk|de|ctrl|data) at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one word at the falling edge and queue the outputs expected after the next rising edge.
  task automatic drive(input logic rst, input logic [9:0] w, input logic bs, input logic lk,
                       input logic de, input logic [1:0] ctrl, input logic [7:0] dat);
    @(negedge clk_i);
    rst_i  = rst;
    tmds_i = w;
    if (rst) exp_slips = 16'h0000;
`ifdef TMDS_DECODER_STATS_EN
    else if (bs && exp_slips != 16'hFFFF) exp_slips = exp_slips + 16'h0001;
`endif
    exp_q.push_back({exp_slips, bs, lk, de, ctrl, dat});
  endtask

  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [28:0] e;
      e = exp_q.pop_front();
      check_eq("out", {3'b000, slip_count_o, bitslip_o, locked_o, de_o, ctrl_o, data_o}, {3'b000, e});
    end
  end

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  // Transmit-side encoding with caller-chosen XOR/XNOR and inversion.
  function automatic logic [9:0] enc(input logic [7:0] b, input logic use_xor, input logic inv);
    logic [7:0] q;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = use_xor ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
    return {inv, use_xor, inv ? ~q : q};
  endfunction

  task automatic lock_on(input logic [9:0] tok);
    for (int i = 0; i < 16; i++) drive(1'b0, tok, 1'b0, (i == 15), 1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] w;

    // Lock on 0x354, then data decode and control tracking.
    drive(1'b1, 10'h000, 0, 0, 0, 2'b00, 8'h00);
    lock_on(10'h354);
    drive(1'b0, 10'h354, 0, 1, 0, 2'b00, 8'h00);
    drive(1'b0, 10'h200, 0, 1, 1, 2'b00, 8'hFF);
    drive(1'b0, 10'h100, 0, 1, 1, 2'b00, 8'h00);
    drive(1'b0, 10'h2AB, 0, 1, 0, 2'b11, 8'h00);
    for (int i = 0; i < 24; i++) begin
      do begin
        b = 8'($urandom_range(0, 255));
        w = enc(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end while (is_token(w));
      drive(1'b0, w, 0, 1, 1, 2'b11, b);
    end
    drive(1'b0, 10'h0AB, 0, 1, 0, 2'b01, 8'h00);
    drive(1'b0, 10'h100, 0, 1, 1, 2'b01, 8'h00);

    // Reset while data is flowing; lock needs 16 fresh tokens.
    drive(1'b1, 10'h200, 0, 0, 0, 2'b00, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b0, 10'h200, 0, 0, 0, 2'b00, 8'h00);
    lock_on(10'h354);
    drive(1'b0, 10'h200, 0, 1, 1, 2'b00, 8'hFF);

    // A data word inside the token run restarts the count.
    drive(1'b1, 10'h000, 0, 0, 0, 2'b00, 8'h00);
    for (int i = 0; i < 15; i++) drive(1'b0, 10'h154, 0, 0, 0, 2'b00, 8'h00);
    drive(1'b0, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    lock_on(10'h154);
    drive(1'b0, 10'h154, 0, 1, 0, 2'b10, 8'h00);

    // Loss of lock after 2048 consecutive data words; 0x155 decodes to 0xFF.
    for (int k = 1; k <= 2048; k++) begin
      if (k < 2048) drive(1'b0, 10'h155, 0, 1, 1, 2'b10, 8'hFF);
      else          drive(1'b0, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    end
    drive(1'b0, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    drive(1'b0, 10'h354, 0, 0, 0, 2'b00, 8'h00);

    // Continuous data from reset: slips at 2048 and 2048+4+2048 cycles after release.
    drive(1'b1, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    for (int k = 1; k <= 4104; k++) begin
      drive(1'b0, 10'h155, ((k == 2048) || (k == 4100)), 0, 0, 2'b00, 8'h00);
    end

    // Reset in the middle of SLIP clears everything.
    drive(1'b1, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    for (int k = 1; k <= 2049; k++) drive(1'b0, 10'h155, (k == 2048), 0, 0, 2'b00, 8'h00);
    drive(1'b1, 10'h155, 0, 0, 0, 2'b00, 8'h00);
    for (int k = 1; k <= 4; k++) drive(1'b0, 10'h155, 0, 0, 0, 2'b00, 8'h00);

    @(negedge clk_i);
    @(posedge clk_i);
    #2;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side TMDS channel decoder for the HDMI/DVI path. It takes one 10-bit parallel word per pixel clock from a deserializer and finds symbol alignment by searching for control tokens, requesting bit-slips from the deserializer until it locks. Once locked, it decodes each word into 8-bit pixel data or a 2-bit control value plus a data-enable. One instance serves one TMDS channel; it is the inverse of the transmit-side `tmds_encoder`.

## Interface
Parameters:
- `LOCK_COUNT`, 16: consecutive control tokens required to declare lock.
- `SEARCH_TIMEOUT`, 2048: cycles in SEARCH without lock before a bit-slip is requested.
- `SLIP_WAIT`, 4: cycles spent in SLIP, including the pulse cycle, before search resumes.
- `LOSS_TIMEOUT`, 2048: cycles in LOCKED without any control token before lock is dropped.

Ports:
- `clk_i` in 1: pixel clock. The block uses this one clock only.
- `rst_i` in 1: synchronous, active-high reset.
- `tmds_i` in 10: raw symbol from the deserializer, bit 0 first on the wire.
- `bitslip_o` out 1: one-cycle pulse asking the deserializer to rotate by 1 bit.
- `locked_o` out 1: alignment achieved.
- `data_o` out 8: decoded pixel byte.
- `ctrl_o` out 2: decoded control value {C1,C0}.
- `de_o` out 1: `data_o` holds a valid pixel byte.
- `slip_count_o` out 16: count of bit-slips issued (see Configuration).

## Operation
- Control tokens, written as `tmds_i[9:0]`:
  - 0x354 → ctrl 00
  - 0x0AB → ctrl 01
  - 0x154 → ctrl 10
  - 0x2AB → ctrl 11
  - Any other word is a data word.
- Data decode:
  - d = `tmds_i[9]` ? ~`tmds_i[7:0]` : `tmds_i[7:0]`.
  - out[0] = d[0].
  - For i = 1..7: out[i] = `tmds_i[8]` ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states are SEARCH (reset state), SLIP and LOCKED.
- SEARCH:
  - `tok_cnt` increments on each token and clears on each data word.
  - `to_cnt` increments every cycle.
  - If the current word is a token and `tok_cnt` == LOCK_COUNT-1, go to LOCKED.
  - Otherwise, if `to_cnt` == SEARCH_TIMEOUT-1, go to SLIP.
  - If both conditions hold in the same cycle, lock wins.
- SLIP:
  - `bitslip_o` is high during the first SLIP cycle only.
  - After SLIP_WAIT cycles, return to SEARCH with `tok_cnt` and `to_cnt` cleared.
  - `tmds_i` is ignored while in SLIP.
- LOCKED:
  - `loss_cnt` clears on each token and increments on each data word.
  - When `loss_cnt` == LOSS_TIMEOUT-1 and the current word is data, go to SEARCH with all counters cleared.
- Outputs are computed from the current state and `tmds_i`:
  - SEARCH or SLIP: `data_o`=0, `ctrl_o`=0, `de_o`=0.
  - LOCKED, token word: `de_o`=0, `ctrl_o`=token value, `data_o`=0.
  - LOCKED, data word: `de_o`=1, `data_o`=decoded byte, `ctrl_o` holds its last value.
- Counters are sized $clog2 of their limit plus 1 and never wrap. Each one is cleared on every state exit.

## Timing
- Reset: `rst_i` sampled high at an edge puts the FSM in SEARCH and clears all counters. At that same edge all outputs go to 0, including `slip_count_o`. This applies from any state, including mid-LOCKED and mid-SLIP.
- Decode latency: `tmds_i` sampled at edge N appears on `data_o`/`ctrl_o`/`de_o` after edge N. All outputs are registered.
- `locked_o` is the registered state==LOCKED.
- Lock: the final token is sampled at edge N, and `locked_o` rises after edge N. That word's own outputs are still zero. The first decoded word is the one sampled at N+1.
- Loss: the final data word is sampled at edge N, and `locked_o` falls after edge N. That word's `de_o` is 0.
- Slip:
  - `bitslip_o` rises after the edge that enters SLIP and falls after the next edge.
  - No further pulse can occur for at least SLIP_WAIT + SEARCH_TIMEOUT cycles after it.

## Configuration
- `TMDS_DECODER_STATS_EN`:
  - Defined: `slip_count_o` increments by 1 on each `bitslip_o` pulse, in the same cycle as the pulse. It saturates at 0xFFFF and clears only on `rst_i`.
  - Undefined: `slip_count_o` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then 16× 0x354: `locked_o`=1 one cycle after the 16th word is sampled. The next 0x354 gives `ctrl_o`=00, `de_o`=0.
- Locked, then `tmds_i`=0x200: one cycle later `data_o`=0xFF, `de_o`=1. Then 0x100 gives `data_o`=0x00, `de_o`=1. Then 0x2AB gives `ctrl_o`=11, `de_o`=0.
- Reset, then 0x155 continuously: `bitslip_o` is high for exactly one cycle, SEARCH_TIMEOUT cycles after reset release. A second pulse follows SLIP_WAIT+SEARCH_TIMEOUT cycles later. With the macro defined, `slip_count_o` reads 1 and then 2.
- 15× 0x154, one 0x155, then 16× 0x154: `locked_o` rises only after the 32nd word. After that, `ctrl_o`=10.
- Locked, then 2048 data words (0x155): `locked_o` falls after the 2048th word and `de_o`=0 from that word onward.
- Locked with data flowing: assert `rst_i` for one cycle. All outputs are 0 after that edge and `locked_o` stays 0 until 16 fresh tokens have been received.
